// File: rtl/route_reserve_arbiter_if.sv
// Route-reservation bus between the input-port control FSMs and the per-switch arbiter.
// Latency: none, wires only. The arbiter registers everything on its side.
// Backpressure: a request is held valid until a grant pulse comes back. Release is a single-cycle pulse.
//
// Signals:
//   routeReserveRequestValid [N]        bit i: input i has a pending request
//   routeReserveRequest      [N*RW]     field i: requested output index for input i
//   routeRelease             [N]        bit i: input i's tail flit has been forwarded
//   routeReserveStatus       [N]        bit i: one-cycle grant pulse to input i
//   sel                      [N*RW]     field o: input currently driving crossbar output o
//   selValid                 [N]        bit o: crossbar output o is locked and enabled
interface route_reserve_arbiter_if #(
    parameter int N             = 4,
    parameter int REQUEST_WIDTH = 2
);
    logic [N-1:0]               routeReserveRequestValid;
    logic [N*REQUEST_WIDTH-1:0] routeReserveRequest;
    logic [N-1:0]               routeRelease;
    logic [N-1:0]               routeReserveStatus;
    logic [N*REQUEST_WIDTH-1:0] sel;
    logic [N-1:0]               selValid;

    // Input-port side: raises requests and releases, consumes grants.
    modport master (
        output routeReserveRequestValid,
        output routeReserveRequest,
        output routeRelease,
        input  routeReserveStatus,
        input  sel,
        input  selValid
    );

    // Arbiter side.
    modport slave (
        input  routeReserveRequestValid,
        input  routeReserveRequest,
        input  routeRelease,
        output routeReserveStatus,
        output sel,
        output selValid
    );
endinterface

// File: rtl/route_reserve_arbiter.sv
// Per-output round-robin route reservation. Each output is locked to one input until that input releases it.
// Latency: a request sampled at edge t produces the grant pulse and selValid in cycle t+1.
// Backpressure: a losing or blocked request stays pending while its valid is held. A release frees the output one cycle before re-arbitration.
//
// Ports:
//   clk  - single clock domain
//   rst  - synchronous, active-high; drops every lock and resets all round-robin pointers
//   bus  - route_reserve_arbiter_if.slave: requests and releases in; grant pulses and crossbar select out
//
// REQUEST_WIDTH must be at least $clog2(N). A request field >= N matches no output, so it is never granted.
module route_reserve_arbiter #(
    parameter int N             = 4,
    parameter int REQUEST_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    route_reserve_arbiter_if.slave bus
);
    localparam int RW = REQUEST_WIDTH;

    typedef logic [RW-1:0] idx_t;
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Per-output state
    state_t          state_q [N];
    idx_t            owner_q [N];
    idx_t            ptr_q   [N];
    logic [N*RW-1:0] sel_q;
    logic [N-1:0]    status_q;

    // Combinational arbitration results
    logic [N-1:0]    cand [N];      // cand[o][i]: input i wants output o
    logic [N-1:0]    grant_vld;
    idx_t            grant_idx [N];
    logic [N-1:0]    release_hit;   // owner of output o pulsed its release
    logic [N-1:0]    status_nxt;

    // Candidate sets. An output index that does not exist never matches,
    // so out-of-range requests fall out here.
    always_comb begin
        for (int o = 0; o < N; o++) begin
            cand[o] = '0;
            for (int i = 0; i < N; i++) begin
                cand[o][i] = bus.routeReserveRequestValid[i] &&
                             (bus.routeReserveRequest[i*RW +: RW] == idx_t'(o));
            end
        end
    end

    // Round-robin pick, done in two passes over constant indices:
    // 1) the first candidate at or above ptr;
    // 2) otherwise, the first candidate from 0 (this wraps around below ptr).
    // Only IDLE outputs arbitrate. A LOCKED output ignores new requests,
    // including the winner's own request that is still high in the grant cycle.
    always_comb begin
        for (int o = 0; o < N; o++) begin
            grant_vld[o] = 1'b0;
            grant_idx[o] = '0;
            if (state_q[o] == IDLE) begin
                for (int i = 0; i < N; i++) begin
                    if (!grant_vld[o] && cand[o][i] && (idx_t'(i) >= ptr_q[o])) begin
                        grant_vld[o] = 1'b1;
                        grant_idx[o] = idx_t'(i);
                    end
                end
                for (int i = 0; i < N; i++) begin
                    if (!grant_vld[o] && cand[o][i]) begin
                        grant_vld[o] = 1'b1;
                        grant_idx[o] = idx_t'(i);
                    end
                end
            end
        end
    end

    // A release counts only when it comes from the registered owner.
    // Releases from other inputs are dropped.
    always_comb begin
        for (int o = 0; o < N; o++) begin
            release_hit[o] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if ((owner_q[o] == idx_t'(i)) && bus.routeRelease[i]) begin
                    release_hit[o] = 1'b1;
                end
            end
        end
    end

    // Grant pulses, folded from per-output winners onto input bits. An input
    // names only one output, so at most one output can grant to it.
    always_comb begin
        status_nxt = '0;
        for (int i = 0; i < N; i++) begin
            for (int o = 0; o < N; o++) begin
                if (grant_vld[o] && (grant_idx[o] == idx_t'(i))) begin
                    status_nxt[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < N; o++) begin
                state_q[o] <= IDLE;
                owner_q[o] <= '0;
                ptr_q[o]   <= '0;
            end
            sel_q    <= '0;
            status_q <= '0;
        end else begin
            status_q <= status_nxt;
            for (int o = 0; o < N; o++) begin
                case (state_q[o])
                    IDLE: begin
                        if (grant_vld[o]) begin
                            state_q[o]          <= LOCKED;
                            owner_q[o]          <= grant_idx[o];
                            sel_q[o*RW +: RW]   <= grant_idx[o];
                            // The winner moves to lowest priority for this output.
                            ptr_q[o]            <= (grant_idx[o] == idx_t'(N-1)) ? '0
                                                   : grant_idx[o] + idx_t'(1);
                        end
                    end
                    LOCKED: begin
                        // A release takes priority over a pending request. The output
                        // spends one IDLE cycle before it can be granted again.
                        // sel keeps its last value.
                        if (release_hit[o]) begin
                            state_q[o] <= IDLE;
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        for (int o = 0; o < N; o++) begin
            bus.selValid[o] = (state_q[o] == LOCKED);
        end
    end

    assign bus.sel                = sel_q;
    assign bus.routeReserveStatus = status_q;

endmodule

// File: tb/tb_route_reserve_arbiter.sv
// Bench for route_reserve_arbiter (N=4, REQUEST_WIDTH=2): table of per-cycle vectors plus a release/request race sequence.
// Latency: each row's expected outputs are checked 1 ns after the edge that samples that row's inputs.
// Backpressure: none. The bench drives every cycle and checks in order through a scoreboard queue.
module tb_route_reserve_arbiter;
    localparam int N  = 4;
    localparam int RW = 2;

    logic clk;
    logic rst;

    route_reserve_arbiter_if #(.N(N), .REQUEST_WIDTH(RW)) bus ();

    route_reserve_arbiter #(.N(N), .REQUEST_WIDTH(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [3:0] vld;
        logic [7:0] req;
        logic [3:0] rel;
        logic [3:0] st;
        logic [7:0] sel;
        logic [3:0] sv;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic add(input logic r, input logic [3:0] vld, input logic [7:0] req,
                       input logic [3:0] rel, input logic [3:0] st,
                       input logic [7:0] sel, input logic [3:0] sv);
        vec_t v;
        v.r = r; v.vld = vld; v.req = req; v.rel = rel;
        v.st = st; v.sel = sel; v.sv = sv;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input int row,
                         input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] vld,
                         input logic [7:0] req, input logic [3:0] rel);
        rst                          = r;
        bus.routeReserveRequestValid = vld;
        bus.routeReserveRequest      = req;
        bus.routeRelease             = rel;
    endtask

    // No two locked outputs may share an owner.
    always @(negedge clk) begin
        if (!rst) begin
            for (int a = 0; a < N; a++) begin
                for (int b = a + 1; b < N; b++) begin
                    if (bus.selValid[a] && bus.selValid[b] &&
                        bus.sel[a*RW +: RW] == bus.sel[b*RW +: RW]) begin
                        n_err++;
                        $display("FAIL owner_unique: outputs %0d and %0d both owned by %0d",
                                 a, b, bus.sel[a*RW +: RW]);
                    end
                end
            end
        end
    end

    initial begin
        vec_t e;
        int   lat;

        drive(1'b1, 4'b0, 8'h00, 4'b0);

        //      rst  vld      req    rel      status   sel    selValid
        add(1'b1, 4'b0000, 8'h00, 4'b0000, 4'b0000, 8'h00, 4'b0000); // reset
        // input 2 -> output 3
        add(1'b0, 4'b0100, 8'h30, 4'b0000, 4'b0100, 8'h80, 4'b1000);
        add(1'b0, 4'b0100, 8'h30, 4'b0000, 4'b0000, 8'h80, 4'b1000); // req still high, no 2nd pulse
        add(1'b0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 8'h80, 4'b1000);
        add(1'b0, 4'b0000, 8'h00, 4'b0100, 4'b0000, 8'h80, 4'b0000); // release
        add(1'b0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 8'h80, 4'b0000);
        // inputs 0,1,3 -> output 1; grant order 0,1,3
        add(1'b0, 4'b1011, 8'h45, 4'b0000, 4'b0001, 8'h80, 4'b0010);
        for (int k = 0; k < 4; k++)
            add(1'b0, 4'b1010, 8'h45, 4'b0000, 4'b0000, 8'h80, 4'b0010);
        add(1'b0, 4'b1010, 8'h45, 4'b0001, 4'b0000, 8'h80, 4'b0000);
        add(1'b0, 4'b1010, 8'h45, 4'b0000, 4'b0010, 8'h84, 4'b0010);
        for (int k = 0; k < 4; k++)
            add(1'b0, 4'b1000, 8'h45, 4'b0000, 4'b0000, 8'h84, 4'b0010);
        add(1'b0, 4'b1000, 8'h45, 4'b0010, 4'b0000, 8'h84, 4'b0000);
        add(1'b0, 4'b1000, 8'h45, 4'b0000, 4'b1000, 8'h8C, 4'b0010);
        add(1'b0, 4'b0000, 8'h00, 4'b0001, 4'b0000, 8'h8C, 4'b0010); // non-owner release
        add(1'b0, 4'b0000, 8'h00, 4'b1000, 4'b0000, 8'h8C, 4'b0000);
        // ptr[1]=2 after a grant to input 1; then 0 and 1 contend
        add(1'b0, 4'b0010, 8'h04, 4'b0000, 4'b0010, 8'h84, 4'b0010);
        add(1'b0, 4'b0000, 8'h00, 4'b0010, 4'b0000, 8'h84, 4'b0000);
        add(1'b0, 4'b0011, 8'h05, 4'b0000, 4'b0001, 8'h80, 4'b0010); // input 0 wins
        add(1'b0, 4'b0010, 8'h05, 4'b0000, 4'b0000, 8'h80, 4'b0010);
        add(1'b0, 4'b0010, 8'h05, 4'b0001, 4'b0000, 8'h80, 4'b0000);
        add(1'b0, 4'b0010, 8'h05, 4'b0000, 4'b0010, 8'h84, 4'b0010);
        add(1'b0, 4'b0000, 8'h00, 4'b0010, 4'b0000, 8'h84, 4'b0000);
        // output 2 locked to input 3; release from input 0 ignored
        add(1'b0, 4'b1000, 8'h80, 4'b0000, 4'b1000, 8'hB4, 4'b0100);
        add(1'b0, 4'b0000, 8'h00, 4'b0001, 4'b0000, 8'hB4, 4'b0100);
        add(1'b0, 4'b0000, 8'h00, 4'b1000, 4'b0000, 8'hB4, 4'b0000);
        add(1'b0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 8'hB4, 4'b0000);
        // four distinct outputs in parallel
        add(1'b0, 4'b1111, 8'hB1, 4'b0000, 4'b1111, 8'hB1, 4'b1111);
        add(1'b0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 8'hB1, 4'b1111);
        add(1'b0, 4'b0000, 8'h00, 4'b1100, 4'b0000, 8'hB1, 4'b0011);
        // reset mid-packet with outputs 0,1 locked, then ptr back to 0
        add(1'b1, 4'b0000, 8'h00, 4'b0000, 4'b0000, 8'h00, 4'b0000);
        add(1'b0, 4'b0110, 8'h00, 4'b0000, 4'b0010, 8'h01, 4'b0001);
        add(1'b0, 4'b0100, 8'h00, 4'b0010, 4'b0000, 8'h01, 4'b0000);
        add(1'b0, 4'b0100, 8'h00, 4'b0000, 4'b0100, 8'h02, 4'b0001);
        add(1'b0, 4'b0000, 8'h00, 4'b0100, 4'b0000, 8'h02, 4'b0000);
        add(1'b0, 4'b0000, 8'h00, 4'b1111, 4'b0000, 8'h02, 4'b0000); // release on idle outputs

        for (int r = 0; r < tbl.size(); r++) begin
            drive(tbl[r].r, tbl[r].vld, tbl[r].req, tbl[r].rel);
            exp_q.push_back(tbl[r]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check("status",   r, {4'b0, bus.routeReserveStatus}, {4'b0, e.st});
            check("sel",      r, bus.sel,                        e.sel);
            check("selValid", r, {4'b0, bus.selValid},           {4'b0, e.sv});
        end

        // Release and a competing request arrive in the same cycle. The new
        // grant must come exactly two cycles after the release pulse.
        drive(1'b0, 4'b1000, 8'h00, 4'b0000);          // input 3 -> output 0 (ptr[0]=3)
        @(posedge clk);
        #1;
        check("race_grant3", 0, {4'b0, bus.routeReserveStatus}, 8'h08);
        check("race_sel3",   0, bus.sel, 8'h03);
        drive(1'b0, 4'b0010, 8'h00, 4'b1000);          // input 1 requests, input 3 releases
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            drive(1'b0, 4'b0010, 8'h00, 4'b0000);
            if (bus.routeReserveStatus[1] && lat == 0) lat = c;
            if (lat != 0) break;
        end
        check("race_latency", 0, 8'(lat), 8'd2);
        check("race_sel1",    0, bus.sel, 8'h01);
        check("race_sv",      0, {4'b0, bus.selValid}, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/route_reserve_arbiter.md
Name: route_reserve_arbiter

Overview:
- Switch-side responder for the route-reservation protocol that each input port's head-flit logic initiates.
- Each input port raises a request naming one output port. The block arbitrates per output with a round-robin scheme, holds the output locked to the winning input until that input's tail flit has passed, and drives the crossbar select.
- There is one instance per switch, between the N input-port control FSMs and the crossbar.

Parameters:
- N, 4, number of switch ports; inputs and outputs are both indexed 0..N-1 (mesh encoding 0 North, 1 South, 2 West, 3 East).
- REQUEST_WIDTH, 2, width of one output-port index; must be at least $clog2(N).

Ports:
- clk  input  1  clock; single clock domain.
- rst  input  1  reset, synchronous, active-high.
- routeReserveRequestValid  input  N  bit i: input port i requests an output; held high until granted.
- routeReserveRequest  input  N*REQUEST_WIDTH  field i ([i*REQUEST_WIDTH +: REQUEST_WIDTH]): requested output index for input i.
- routeRelease  input  N  bit i: one-cycle pulse from input i's FSM once its tail flit has been forwarded.
- routeReserveStatus  output  N  bit i: one-cycle grant pulse to input i.
- sel  output  N*REQUEST_WIDTH  field o: index of the input driving output o.
- selValid  output  N  bit o: output o is locked to an input; crossbar output o is enabled.

Behaviour:
- Per-output FSM with two states.
  - IDLE: selValid[o]=0.
  - LOCKED: selValid[o]=1, owner[o] is registered.
- Candidate set for output o:
  - input i is a candidate iff routeReserveRequestValid[i]=1 and routeReserveRequest field i == o;
  - request fields >= N are ignored and never granted.
- IDLE with a non-empty candidate set:
  - choose the first candidate scanning i = ptr[o], ptr[o]+1, ... modulo N;
  - next cycle: state LOCKED, owner[o]=i, sel field o = i, selValid[o]=1, routeReserveStatus[i]=1 for exactly that cycle;
  - ptr[o] <= (i+1) mod N at the same edge.
- Latency: request sampled at edge t yields grant pulse and selValid in cycle t+1.
- LOCKED:
  - a new request for o is not granted; it stays pending while its valid remains high;
  - the request of the granted input may still be high during the grant-pulse cycle; it must not produce a second pulse.
- Release:
  - routeRelease[owner[o]]=1 while LOCKED returns output o to IDLE at the next edge;
  - selValid[o] drops; the sel field holds its last value;
  - a release from a non-owner input, or for an IDLE output, is ignored.
- Release and a pending request in the same cycle: release wins. The output is IDLE for one cycle and arbitration happens in that IDLE cycle, so the new grant appears 2 cycles after the release pulse.
- Independent outputs are arbitrated in parallel. Several outputs may grant in the same cycle, to different inputs.
- A single input can request only one output at a time, so routeReserveStatus is never double-pulsed for one input.
- Reset, including mid-packet:
  - all outputs IDLE; selValid=0, sel=0, routeReserveStatus=0, all ptr=0;
  - any lock in progress is dropped.
- Invariant: no two LOCKED outputs share the same owner (assertion in bench).

Test Plan:
- After reset, input 2 requests output 3 at cycle 1 -> cycle 2: routeReserveStatus=4'b0100, sel[7:6]=2, selValid=4'b1000; cycle 3: status=0, lock held.
- Inputs 0,1,3 all request output 1 simultaneously, each released 4 cycles after its grant -> grant order 0, 1, 3; each grant 2 cycles after the previous release; sel[3:2] follows 0,1,3.
- Contention round-robin: after ptr[1]=2 (last grant to input 1), inputs 0 and 1 request output 1 -> input 0 is not starved (scan order 2,3,0): grant to input 0 first.
- routeRelease[0] pulsed while output 2 is locked to input 3 -> no state change; routeRelease[3] -> selValid[2]=0 next cycle.
- Four inputs requesting four distinct outputs (0->1, 1->0, 2->3, 3->2) -> all four grant pulses in the same cycle (status=4'b1111), selValid=4'b1111, sel=8'b10_11_00_01.
- rst asserted while outputs 0 and 1 are locked -> next cycle selValid=0, sel=0, status=0; a request re-presented afterwards is granted with ptr=0 priority.
